// File: rtl/mnist_pkg.sv
// Shared constants and input-FSM encoding for the MNIST frame loader.
package mnist_pkg;
   localparam int N_PIX     = 784;
   localparam int N_CLASS   = 10;
   localparam int PIX_LSB   = 10;
   localparam int LABEL_LSB = 0;
   localparam int IMG_W     = N_PIX + N_CLASS;

   typedef enum logic [1:0] {
      ST_LABEL  = 2'd0,
      ST_PIXELS = 2'd1,
      ST_FULL   = 2'd2
   } ld_state_e;
endpackage

// File: rtl/mnist_hold_timer.sv
// Output register for the training vector: holds each frame for HOLD_CYCLES,
// blanks it when idle and reports when a new frame may be loaded.
module mnist_hold_timer #(
   parameter int IMG_W       = 794,
   parameter int HOLD_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [IMG_W-1:0] load_img,
   output logic [IMG_W-1:0] image_data,
   output logic             frame_valid,
   output logic             free,
   output logic [15:0]      frame_cnt
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   logic [IMG_W-1:0] img_q, img_d;
   logic             vld_q, vld_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [15:0]      cnt_q, cnt_d;

   // A new frame may land on the same edge the current one expires.
   assign free = !vld_q || (hold_q == HW'(1));

   always_comb begin
      img_d  = img_q;
      vld_d  = vld_q;
      hold_d = hold_q;
      cnt_d  = cnt_q;
      if (load) begin
         img_d  = load_img;
         vld_d  = 1'b1;
         hold_d = HW'(HOLD_CYCLES);
         cnt_d  = cnt_q + 16'd1;
      end else if (vld_q) begin
         hold_d = hold_q - HW'(1);
         if (hold_q == HW'(1)) begin
            vld_d = 1'b0;
            img_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         img_q  <= '0;
         vld_q  <= 1'b0;
         hold_q <= '0;
         cnt_q  <= '0;
      end else begin
         img_q  <= img_d;
         vld_q  <= vld_d;
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

   assign image_data  = img_q;
   assign frame_valid = vld_q;
   assign frame_cnt   = cnt_q;
endmodule

// File: rtl/mnist_frame_loader.sv
// Byte-stream MNIST loader: label + binarized pixels into a shadow buffer,
// then handed to the hold timer as a one-hot-labelled training vector.
module mnist_frame_loader #(
   parameter int N_PIX       = mnist_pkg::N_PIX,
   parameter int N_CLASS     = mnist_pkg::N_CLASS,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               pix_thresh,
   input  logic                     s_valid,
   input  logic [7:0]               s_data,
   output logic                     s_ready,
   output logic [N_PIX+N_CLASS-1:0] image_data,
   output logic                     frame_valid,
   output logic                     label_err,
   output logic [15:0]              frame_cnt
);
   import mnist_pkg::*;

   localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam int IW    = N_PIX + N_CLASS;

   ld_state_e          state_q, state_d;
   logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [7:0]         label_q, label_d;
   logic [N_PIX-1:0]   shadow_q, shadow_d;
   logic               label_ok;
   logic [N_CLASS-1:0] onehot;
   logic               load, free;

   assign label_ok = int'(label_q) < N_CLASS;
   assign onehot   = label_ok ? (N_CLASS'(1) << label_q) : '0;

   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      label_d   = label_q;
      shadow_d  = shadow_q;
      s_ready   = 1'b0;
      label_err = 1'b0;
      load      = 1'b0;
      case (state_q)
         ST_LABEL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               label_d   = s_data;
               pix_cnt_d = '0;
               state_d   = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            s_ready = 1'b1;
            if (s_valid) begin
               shadow_d[pix_cnt_q] = (s_data >= pix_thresh);
               if (pix_cnt_q == CNT_W'(N_PIX - 1)) state_d = ST_FULL;
               else                                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
         end
         ST_FULL: begin
            // Bad labels drop the frame at once without waiting for the output.
            if (!label_ok) begin
               label_err = 1'b1;
               state_d   = ST_LABEL;
            end else if (free) begin
               load    = 1'b1;
               state_d = ST_LABEL;
            end
         end
         default: state_d = ST_LABEL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LABEL;
         pix_cnt_q <= '0;
         label_q   <= '0;
         shadow_q  <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         label_q   <= label_d;
         shadow_q  <= shadow_d;
      end
   end

   mnist_hold_timer #(
      .IMG_W       (IW),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_img    ({shadow_q, onehot}),
      .image_data  (image_data),
      .frame_valid (frame_valid),
      .free        (free),
      .frame_cnt   (frame_cnt)
   );
endmodule

// File: tb/tb_mnist_frame_loader.sv
// Bench: full-size loader against a frame-level model plus literal checks,
// and a tiny 2-pixel/4-cycle-hold instance checked against a hand timeline.
module tb_mnist_frame_loader;
   localparam int NP  = 784;
   localparam int NC  = 10;
   localparam int IW  = NP + NC;
   localparam int IWB = 2 + NC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]    thr;
   logic          sv_a, sr_a, fv_a, le_a;
   logic [7:0]    sd_a;
   logic [IW-1:0] img_a;
   logic [15:0]   fc_a;
   logic          sv_b, sr_b, fv_b, le_b;
   logic [7:0]    sd_b;
   logic [IWB-1:0] img_b;
   logic [15:0]   fc_b;

   mnist_frame_loader dut_a (
      .clk(clk), .rst_n(rst_n), .pix_thresh(thr), .s_valid(sv_a), .s_data(sd_a),
      .s_ready(sr_a), .image_data(img_a), .frame_valid(fv_a), .label_err(le_a),
      .frame_cnt(fc_a));

   mnist_frame_loader #(.N_PIX(2), .N_CLASS(NC), .HOLD_CYCLES(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .pix_thresh(thr), .s_valid(sv_b), .s_data(sd_b),
      .s_ready(sr_b), .image_data(img_b), .frame_valid(fv_b), .label_err(le_b),
      .frame_cnt(fc_b));

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int pat, input int k);
      case (pat)
         0:       return (k % 2 == 1) ? 8'hFF : 8'h00;
         1:       return (k == 0) ? 8'h7F : (k == 1) ? 8'h80 : 8'h00;
         default: return 8'((k * 37 + 11) % 256);
      endcase
   endfunction

   // Frame-level model of dut_a: bytes collected, pending frame, cycles left on display.
   int            m_nb, m_left;
   logic [7:0]    m_label;
   logic [NP-1:0] m_bits;
   logic          m_pend, m_pbad;
   logic [IW-1:0] m_pimg, m_cur;
   logic [15:0]   m_cnt;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_nb = 0; m_left = 0; m_label = '0; m_bits = '0; m_pend = 0;
            m_pbad = 0; m_pimg = '0; m_cur = '0; m_cnt = '0;
         end
         chk("a_s_ready", sr_a, !m_pend);
         chk("a_label_err", le_a, m_pend && m_pbad);
         chk("a_frame_valid", fv_a, m_left > 0);
         chk("a_image_data", img_a, (m_left > 0) ? m_cur : '0);
         chk("a_frame_cnt", fc_a, m_cnt);
         @(posedge clk);
         if (rst_n) begin
            if (m_pend) begin
               if (m_pbad) begin
                  m_pend = 0;
                  if (m_left > 0) m_left--;
               end else if (m_left <= 1) begin
                  m_cur  = m_pimg;
                  m_left = 1;
                  m_cnt  = m_cnt + 16'd1;
                  m_pend = 0;
               end else m_left--;
            end else begin
               if (m_left > 0) m_left--;
               if (sv_a) begin
                  if (m_nb == 0) m_label = sd_a;
                  else           m_bits[m_nb-1] = (sd_a >= thr);
                  m_nb++;
                  if (m_nb == NP + 1) begin
                     m_nb   = 0;
                     m_pend = 1;
                     m_pbad = m_label > 8'd9;
                     m_pimg = {m_bits, 10'b0};
                     if (!m_pbad) m_pimg[m_label] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic send_a(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) while ($urandom_range(0, 1) == 1) begin
         sv_a = 0; sd_a = 8'($urandom);
         @(posedge clk); #1;
      end
      sv_a = 1; sd_a = b; n = 0;
      while (!sr_a && n < 1000) begin @(posedge clk); #1; n++; end
      if (n >= 1000) begin
         checks++; fails++;
         $display("FAIL a_handshake_timeout actual=stalled required=ready");
      end
      @(posedge clk); #1;
      sv_a = 0;
   endtask

   task automatic send_frame_a(input logic [7:0] lab, input int pat, input bit gaps, input int npx);
      send_a(lab, gaps);
      for (int k = 0; k < npx; k++) send_a(pix(pat, k), gaps);
   endtask

   task automatic send_b(input logic [7:0] b);
      int n;
      sv_b = 1; sd_b = b; n = 0;
      while (!sr_b && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         checks++; fails++;
         $display("FAIL b_handshake_timeout actual=stalled required=ready");
      end
      @(posedge clk); #1;
      sv_b = 0;
   endtask

   logic [NP-1:0]  alt_bits, all_ones;
   logic           log_fv [14];
   logic           log_rdy [14];
   logic [IWB-1:0] log_img [14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NP; k++) alt_bits[k] = (k % 2 == 1);
      all_ones = '1;
      thr = 8'h80; sv_a = 0; sd_a = 0; sv_b = 0; sd_b = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_ready", sr_a, 1'b1);
      chk("rst_valid", fv_a, 1'b0);
      chk("rst_image", img_a, '0);
      chk("rst_cnt", fc_a, 16'd0);

      // label 5, alternating pixels
      send_frame_a(8'd5, 0, 0, NP);
      @(negedge clk);
      chk("f1_full_ready", sr_a, 1'b0);
      chk("f1_not_yet", fv_a, 1'b0);
      @(negedge clk);
      chk("f1_valid", fv_a, 1'b1);
      chk("f1_label", img_a[9:0], 10'h020);
      chk("f1_pix_lo", img_a[13:10], 4'b1010);
      chk("f1_pix_hi", img_a[IW-1:IW-4], 4'b1010);
      chk("f1_cnt", fc_a, 16'd1);
      @(negedge clk);
      chk("f1_gone", fv_a, 1'b0);
      chk("f1_blank", img_a, '0);

      // threshold edge: 0x7F -> 0, 0x80 -> 1
      send_frame_a(8'd3, 1, 0, NP);
      repeat (2) @(negedge clk);
      chk("f2_thresh", img_a[11:10], 2'b10);
      chk("f2_label", img_a[9:0], 10'h008);
      chk("f2_cnt", fc_a, 16'd2);

      thr = 8'h00;
      send_frame_a(8'd9, 1, 0, NP);
      repeat (2) @(negedge clk);
      chk("f3_all_ones", img_a[IW-1:10], all_ones);
      chk("f3_label", img_a[9:0], 10'h200);
      thr = 8'h80;

      // bad label
      send_frame_a(8'd12, 2, 0, NP);
      @(negedge clk);
      chk("f4_err_pulse", le_a, 1'b1);
      @(negedge clk);
      chk("f4_err_clear", le_a, 1'b0);
      chk("f4_no_frame", fv_a, 1'b0);
      chk("f4_cnt", fc_a, 16'd3);

      // same pixels as f1, stalled source
      send_frame_a(8'd0, 0, 1, NP);
      repeat (2) @(negedge clk);
      chk("f5_label", img_a[9:0], 10'h001);
      chk("f5_pixels", img_a[IW-1:10], alt_bits);
      chk("f5_cnt", fc_a, 16'd4);

      // reset mid-frame
      send_frame_a(8'd7, 2, 0, 300);
      rst_n = 0;
      #1;
      chk("mid_rst_cnt", fc_a, 16'd0);
      chk("mid_rst_valid", fv_a, 1'b0);
      chk("mid_rst_image", img_a, '0);
      chk("mid_rst_err", le_a, 1'b0);
      @(posedge clk); #1 rst_n = 1;
      send_frame_a(8'd2, 0, 0, NP);
      repeat (2) @(negedge clk);
      chk("f7_label", img_a[9:0], 10'h004);
      chk("f7_pixels", img_a[IW-1:10], alt_bits);
      chk("f7_cnt", fc_a, 16'd1);

      // two back-to-back frames on the 4-cycle-hold instance
      @(posedge clk); #1;
      fork
         begin
            send_b(8'd1); send_b(8'hFF); send_b(8'h00);
            send_b(8'd2); send_b(8'h00); send_b(8'hFF);
         end
         begin
            for (int k = 0; k < 14; k++) begin
               @(negedge clk);
               log_fv[k] = fv_b; log_img[k] = img_b; log_rdy[k] = sr_b;
            end
         end
      join
      for (int k = 0; k < 14; k++) begin
         chk($sformatf("b_valid_c%0d", k), log_fv[k], (k >= 4 && k <= 11));
         chk($sformatf("b_image_c%0d", k), log_img[k],
             (k >= 4 && k <= 7) ? 12'h402 : (k >= 8 && k <= 11) ? 12'h804 : 12'h000);
         chk($sformatf("b_ready_c%0d", k), log_rdy[k], !(k == 3 || k == 7));
      end
      chk("b_cnt", fc_b, 16'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
